// File: rtl/mips_image_loader_if.sv
// mips_image_loader_if
//   Bundles the boot loader's control, byte-stream and memory-write signals.
//   slave  : the loader side (receives start/stream, drives writes/status)
//   master : the host side (drives start/stream, observes writes/status)
//   Signals:
//     start_i/sel_i       load request pulse and image select
//     s_data_i/s_valid_i  stream byte and valid, s_ready_o back-pressure
//     imem_we_o/dmem_we_o word write strobes, mem_addr_o/mem_wdata_o payload
//     pc_init_o/sp_init_o header word 0 of the I/D image, init_we_o update pulse
//     busy_o/done_o/err_o load status, cpu_rst_o core reset
interface mips_image_loader_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              start_i;
  logic              sel_i;
  logic [7:0]        s_data_i;
  logic              s_valid_i;
  logic              s_ready_o;
  logic              imem_we_o;
  logic              dmem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       pc_init_o;
  logic [31:0]       sp_init_o;
  logic              init_we_o;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic              cpu_rst_o;

  modport slave (
    input  start_i, sel_i, s_data_i, s_valid_i,
    output s_ready_o, imem_we_o, dmem_we_o, mem_addr_o, mem_wdata_o,
           pc_init_o, sp_init_o, init_we_o, busy_o, done_o, err_o, cpu_rst_o
  );

  modport master (
    output start_i, sel_i, s_data_i, s_valid_i,
    input  s_ready_o, imem_we_o, dmem_we_o, mem_addr_o, mem_wdata_o,
           pc_init_o, sp_init_o, init_we_o, busy_o, done_o, err_o, cpu_rst_o
  );
endinterface

// File: rtl/mips_image_loader.sv
// mips_image_loader
//   Boot loader for the single-cycle MIPS core. Takes a byte stream holding
//   an instruction or data image (header word 0 = initial PC/$sp, header
//   word 1 = payload word count N, then N payload words, MSB-first), writes
//   the payload into the selected memory and keeps the core in reset until
//   both images have loaded.
//   Ports:
//     clk_i  clock
//     rst_i  synchronous active-high reset
//     bus    mips_image_loader_if.slave (stream in, memory writes/status out)
//   Optional build macro LOADER_CHECKSUM_EN: a trailing word after the payload
//   must equal the 32-bit wrapping sum of the raw payload words.
module mips_image_loader #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MAX_WORDS = 1024,
  parameter bit          IMEM_LE   = 1'b0,
  parameter bit          DMEM_LE   = 1'b1,
  parameter logic [31:0] DBASE     = 32'h0
) (
  input logic                clk_i,
  input logic                rst_i,
  mips_image_loader_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HDR0    = 3'd1,
    S_HDR1    = 3'd2,
    S_PAYLOAD = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    S_CHECK   = 3'd4,
`endif
    S_DONE    = 3'd5,
    S_ERR     = 3'd6
  } state_t;

  // State entered once the payload is exhausted (or N = 0).
`ifdef LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHECK;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t            r_state, w_state_nxt;
  logic              w_ready, w_xfer, w_word_done, w_start, w_last, w_swap;
  logic              w_too_big, w_zero;
  logic [31:0]       w_word;
  logic [1:0]        r_bcnt;
  logic [23:0]       r_shift;
  logic              r_sel;
  logic [CNT_W-1:0]  r_count, r_idx;
  logic [ADDR_W-1:0] r_base, r_addr;
  logic [31:0]       r_wdata, r_pc_init, r_sp_init;
  logic              r_imem_we, r_dmem_we, r_init_we;
  logic              r_ld_i, r_ld_d, r_cpu_rst;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       r_sum;
`endif

`ifdef LOADER_CHECKSUM_EN
  assign w_ready = (r_state inside {S_HDR0, S_HDR1, S_PAYLOAD, S_CHECK});
`else
  assign w_ready = (r_state inside {S_HDR0, S_HDR1, S_PAYLOAD});
`endif
  assign w_start     = bus.start_i & (r_state inside {S_IDLE, S_DONE, S_ERR});
  assign w_xfer      = bus.s_valid_i & w_ready;
  // The fourth byte completes the word in the same cycle it arrives.
  assign w_word      = {r_shift, bus.s_data_i};
  assign w_word_done = w_xfer & (r_bcnt == 2'd3);
  assign w_too_big   = (w_word > 32'(MAX_WORDS));
  assign w_zero      = (w_word == 32'd0);
  assign w_last      = ((r_idx + CNT_W'(1)) == r_count);
  assign w_swap      = r_sel ? DMEM_LE : IMEM_LE;

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: if (w_start) w_state_nxt = S_HDR0;
      S_HDR0: if (w_word_done) w_state_nxt = S_HDR1;
      S_HDR1: if (w_word_done) begin
        if (w_too_big)   w_state_nxt = S_ERR;
        else if (w_zero) w_state_nxt = S_TAIL;
        else             w_state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: if (w_word_done && w_last) w_state_nxt = S_TAIL;
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: if (w_word_done) w_state_nxt = (w_word == r_sum) ? S_DONE : S_ERR;
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sel     <= 1'b0;
      r_bcnt    <= '0;
      r_shift   <= '0;
      r_count   <= '0;
      r_idx     <= '0;
      r_base    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_pc_init <= '0;
      r_sp_init <= '0;
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      r_init_we <= 1'b0;
      r_ld_i    <= 1'b0;
      r_ld_d    <= 1'b0;
      r_cpu_rst <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
`endif
    end else begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      r_init_we <= 1'b0;
      // Registered from the flags, so release lags the second DONE by a cycle.
      r_cpu_rst <= ~(r_ld_i & r_ld_d);

      if (w_start) begin
        r_sel     <= bus.sel_i;
        r_bcnt    <= '0;
        r_cpu_rst <= 1'b1;
        if (bus.sel_i) r_ld_d <= 1'b0;
        else           r_ld_i <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
        r_sum     <= '0;
`endif
      end

      if (w_xfer) begin
        r_bcnt  <= r_bcnt + 2'd1;
        r_shift <= {r_shift[15:0], bus.s_data_i};
      end

      if (w_word_done) begin
        case (r_state)
          S_HDR0: begin
            r_init_we <= 1'b1;
            if (r_sel) r_sp_init <= w_word;
            else       r_pc_init <= w_word;
          end
          S_HDR1: begin
            r_count <= CNT_W'(w_word);
            r_idx   <= '0;
            r_base  <= r_sel ? ADDR_W'(DBASE) : ADDR_W'(r_pc_init);
          end
          S_PAYLOAD: begin
            // Address wraps modulo 2^ADDR_W by plain truncation.
            r_addr    <= r_base + (ADDR_W'(r_idx) << 2);
            r_wdata   <= w_swap ? {w_word[7:0], w_word[15:8], w_word[23:16], w_word[31:24]}
                                : w_word;
            r_imem_we <= ~r_sel;
            r_dmem_we <= r_sel;
            r_idx     <= r_idx + CNT_W'(1);
`ifdef LOADER_CHECKSUM_EN
            r_sum     <= r_sum + w_word;
`endif
          end
          default: ;
        endcase
      end

      if ((w_state_nxt == S_DONE) && (r_state != S_DONE)) begin
        if (r_sel) r_ld_d <= 1'b1;
        else       r_ld_i <= 1'b1;
      end
    end
  end

  assign bus.s_ready_o   = w_ready;
  assign bus.busy_o      = w_ready;
  assign bus.done_o      = (r_state == S_DONE);
  assign bus.err_o       = (r_state == S_ERR);
  assign bus.imem_we_o   = r_imem_we;
  assign bus.dmem_we_o   = r_dmem_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.pc_init_o   = r_pc_init;
  assign bus.sp_init_o   = r_sp_init;
  assign bus.init_we_o   = r_init_we;
  assign bus.cpu_rst_o   = r_cpu_rst;
endmodule

// File: tb/tb_mips_image_loader.sv
// tb_mips_image_loader
//   Self-checking bench for mips_image_loader: a table of images with their
//   expected status, randomized images checked against an address/data model,
//   and a hand-written mid-load reset sequence.
module tb_mips_image_loader;
  localparam int unsigned MAXW    = 1024;
  localparam bit          IMEM_LE = 1'b0;
  localparam bit          DMEM_LE = 1'b1;
  localparam logic [31:0] DBASE   = 32'h0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_image_loader_if #(.ADDR_W(32)) bus();

  mips_image_loader #(
    .ADDR_W(32), .MAX_WORDS(MAXW), .IMEM_LE(IMEM_LE), .DMEM_LE(DMEM_LE), .DBASE(DBASE)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  typedef struct {
    bit          sel;
    logic [31:0] hdr0;
    logic [31:0] n;
    logic [31:0] w0, w1;
    bit          gaps, glitch, bad_ck;
    bit          exp_done, exp_err, exp_cpu, has_w0;
    logic [31:0] exp_a0, exp_d0;
  } img_t;

  typedef struct { bit d; logic [31:0] a; logic [31:0] w; } wr_t;

  wr_t  wr_q[$];
  img_t tbl[$];
  int   cyc = 0, init_cnt = 0, done_rise = -1, cpu_fall = -1, both_we = 0;
  logic prev_done = 1'b0, prev_cpu = 1'b1;
  int   checks = 0, errors = 0;
  bit   loaded [2];

  // Write/status monitor, sampled mid-cycle.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.imem_we_o || bus.dmem_we_o)
      wr_q.push_back('{d: bus.dmem_we_o, a: bus.mem_addr_o, w: bus.mem_wdata_o});
    if (bus.imem_we_o && bus.dmem_we_o) both_we <= both_we + 1;
    if (bus.init_we_o) init_cnt <= init_cnt + 1;
    if (bus.done_o && !prev_done) done_rise <= cyc;
    if (!bus.cpu_rst_o && prev_cpu) cpu_fall <= cyc;
    prev_done <= bus.done_o;
    prev_cpu  <= bus.cpu_rst_o;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(3-i) +: 8];
    return r;
  endfunction

  function automatic img_t mk(input bit sel, input logic [31:0] hdr0, n, w0, w1,
                              input bit gaps, glitch, bad_ck, exp_done, exp_err, exp_cpu,
                              has_w0, input logic [31:0] exp_a0, exp_d0);
    img_t e;
    e.sel = sel; e.hdr0 = hdr0; e.n = n; e.w0 = w0; e.w1 = w1;
    e.gaps = gaps; e.glitch = glitch; e.bad_ck = bad_ck;
    e.exp_done = exp_done; e.exp_err = exp_err; e.exp_cpu = exp_cpu;
    e.has_w0 = has_w0; e.exp_a0 = exp_a0; e.exp_d0 = exp_d0;
    return e;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_s_ready"}, 32'(bus.s_ready_o), 0);
    chk({tag, "_imem_we"}, 32'(bus.imem_we_o), 0);
    chk({tag, "_dmem_we"}, 32'(bus.dmem_we_o), 0);
    chk({tag, "_init_we"}, 32'(bus.init_we_o), 0);
    chk({tag, "_addr"}, bus.mem_addr_o, 0);
    chk({tag, "_wdata"}, bus.mem_wdata_o, 0);
    chk({tag, "_pc_init"}, bus.pc_init_o, 0);
    chk({tag, "_sp_init"}, bus.sp_init_o, 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_done"}, 32'(bus.done_o), 0);
    chk({tag, "_err"}, 32'(bus.err_o), 0);
    chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst_o), 1);
  endtask

  // Called and returns at a negedge; the byte transfers at the posedge between.
  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit glitch, input bit gsel);
    bit ok = 1'b0;
    for (int g = 0; gaps && g < 4 && $urandom_range(0, 2) == 0; g++) begin
      bus.s_valid_i = 1'b0;
      @(negedge clk);
    end
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = b;
    if (glitch) begin
      bus.start_i = 1'b1;
      bus.sel_i   = gsel;
    end
    for (int t = 0; t < 50 && !ok; t++) begin
      ok = bus.s_ready_o;
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    bus.s_valid_i = 1'b0;
    if (!ok) chk("byte_accept_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps, input int glitch_at, input bit gsel);
    for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gaps, glitch_at == i, gsel);
  endtask

  task automatic pulse_start(input bit sel);
    bus.start_i = 1'b1;
    bus.sel_i   = sel;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic run_image(input string tag, input img_t e);
    logic [31:0] words[$];
    logic [31:0] sum = '0;
    logic [31:0] exp_base, exp_a, exp_d;
    int nsend, base_idx, base_init, nseen;
    bit ok = 1'b0;
    nsend = (e.n > 32'(MAXW)) ? 0 : int'(e.n);
    for (int k = 0; k < nsend; k++)
      words.push_back(k == 0 ? e.w0 : (k == 1 ? e.w1 : 32'($urandom())));
    base_idx  = wr_q.size();
    base_init = init_cnt;
    pulse_start(e.sel);
    send_word(e.hdr0, e.gaps, -1, 1'b0);
    send_word(e.n, e.gaps, -1, 1'b0);
    for (int k = 0; k < nsend; k++) begin
      send_word(words[k], e.gaps, (k == 0 && e.glitch) ? 2 : -1, ~e.sel);
      sum += words[k];
    end
`ifdef LOADER_CHECKSUM_EN
    if (e.n <= 32'(MAXW)) send_word(e.bad_ck ? 32'hDEADBEEF : sum, e.gaps, -1, 1'b0);
`endif
    for (int t = 0; t < 40 && !ok; t++) begin
      ok = bus.done_o | bus.err_o;
      if (!ok) @(negedge clk);
    end
    if (!ok) chk({tag, "_finish_timeout"}, 0, 1);
    repeat (3) @(negedge clk);

    chk({tag, "_done"}, 32'(bus.done_o), 32'(e.exp_done));
    chk({tag, "_err"}, 32'(bus.err_o), 32'(e.exp_err));
    chk({tag, "_cpu_rst"}, 32'(bus.cpu_rst_o), 32'(e.exp_cpu));
    chk({tag, "_s_ready"}, 32'(bus.s_ready_o), 0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 0);
    chk({tag, "_init_pulses"}, 32'(init_cnt - base_init), 1);
    chk({tag, "_init_val"}, e.sel ? bus.sp_init_o : bus.pc_init_o, e.hdr0);
    nseen = wr_q.size() - base_idx;
    chk({tag, "_nwrites"}, 32'(nseen), 32'(nsend));
    if (e.has_w0 && nseen > 0) begin
      chk({tag, "_addr0"}, wr_q[base_idx].a, e.exp_a0);
      chk({tag, "_data0"}, wr_q[base_idx].w, e.exp_d0);
    end
    exp_base = e.sel ? DBASE : e.hdr0;
    for (int k = 0; k < nsend && k < nseen; k++) begin
      exp_a = exp_base + 32'(4 * k);
      exp_d = (e.sel ? DMEM_LE : IMEM_LE) ? bswap(words[k]) : words[k];
      if (wr_q[base_idx+k].d !== e.sel) chk({tag, "_wr_mem"}, 32'(wr_q[base_idx+k].d), 32'(e.sel));
      if (wr_q[base_idx+k].a !== exp_a) chk({tag, "_wr_addr"}, wr_q[base_idx+k].a, exp_a);
      chk({tag, "_wr_data"}, wr_q[base_idx+k].w, exp_d);
    end
    if (e.exp_done && !e.exp_cpu)
      chk({tag, "_cpu_rst_lag"}, 32'(cpu_fall - done_rise), 1);
    loaded[e.sel] = e.exp_done;
  endtask

  initial begin
    img_t e;
    bit   l0, l1;
    int   base_idx;

    tbl.push_back(mk(0, 32'h40, 2, 32'h20080005, 32'hFC000000, 0, 0, 0, 1, 0, 1, 1, 32'h40, 32'h20080005));
    tbl.push_back(mk(1, 32'h3FC, 1, 32'h11223344, 0, 0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h44332211));
    tbl.push_back(mk(0, 32'h100, 32'h401, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0));
    tbl.push_back(mk(0, 32'hFFFFFFF8, 3, 32'hAABBCCDD, 32'h01020304, 1, 1, 0, 1, 0, 0, 1, 32'hFFFFFFF8, 32'hAABBCCDD));
    tbl.push_back(mk(1, 32'h7FF0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'h1000, MAXW, 32'hCAFEF00D, 32'h12345678, 0, 0, 0, 1, 0, 0, 1, 32'h0, 32'h0DF0FECA));
`ifdef LOADER_CHECKSUM_EN
    tbl.push_back(mk(0, 32'h200, 2, 32'h1, 32'h2, 1, 1, 1, 0, 1, 1, 1, 32'h200, 32'h1));
`endif

    bus.start_i = 1'b0; bus.sel_i = 1'b0; bus.s_data_i = 8'h0; bus.s_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    loaded[0] = 1'b0; loaded[1] = 1'b0;
    check_reset_state("reset");

    for (int i = 0; i < tbl.size(); i++) run_image($sformatf("tbl%0d", i), tbl[i]);

    for (int r = 0; r < 6; r++) begin
      e = mk($urandom_range(0, 1), 32'($urandom()) & 32'hFFFFFFFC, $urandom_range(0, 6),
             $urandom(), $urandom(), 1, 0, 0, 1, 0, 0, 0, 0, 0);
      e.glitch = (e.n != 0) && ($urandom_range(0, 1) == 1);
      l0 = (e.sel == 1'b0) ? 1'b1 : loaded[0];
      l1 = (e.sel == 1'b1) ? 1'b1 : loaded[1];
      e.exp_cpu = !(l0 && l1);
      run_image($sformatf("rnd%0d", r), e);
    end

    // Reset in the middle of a 3-word payload: only word 0 may be written.
    base_idx = wr_q.size();
    pulse_start(1'b0);
    send_word(32'h80, 0, -1, 1'b0);
    send_word(32'd3, 0, -1, 1'b0);
    send_word(32'h11111111, 0, -1, 1'b0);
    send_byte(8'h22, 0, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    loaded[0] = 1'b0; loaded[1] = 1'b0;
    check_reset_state("midrst");
    repeat (3) @(negedge clk);
    chk("midrst_nwrites", 32'(wr_q.size() - base_idx), 1);
    chk("both_strobes", 32'(both_we), 0);
    run_image("reload_i", tbl[0]);
    run_image("reload_d", tbl[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
